// File: rtl/arm_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | arm_fetch_pkg: fetch-stage states, widths and entry type      |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
package arm_fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [INSTR_W-1:0] next_pc(input logic [INSTR_W-1:0] cur);
    return cur + PC_STEP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------+
// | fetch_buffer: DEPTH-entry {pc, instr} FIFO with sync flush    |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
module fetch_buffer
  import arm_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  fetch_entry_t           wdata_i,
  output fetch_entry_t           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     cnt_q;
  logic            pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPTH_C);
  assign count_o = cnt_q;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Caller guarantees push only when not full or popping in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------+
// | if_fetch_stage: PC owner, req/ack imem fetch, prefetch queue  |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
module if_fetch_stage
  import arm_fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               freeze_i,
  input  logic               branch_taken_i,
  input  logic [INSTR_W-1:0] branch_addr_i,
  output logic               imem_req_o,
  output logic [INSTR_W-1:0] imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [INSTR_W-1:0] instruction_o,
  output logic [INSTR_W-1:0] pc_o,
  output logic               valid_o
);

  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e        state_q, state_d;
  logic [INSTR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [INSTR_W-1:0]  addr_q, addr_d;

  logic                buf_empty, buf_full;
  logic [PW:0]         buf_count;
  fetch_entry_t        head, push_entry;
  logic                push, pop, room;
  logic [CW-1:0]       cnt_next;

  // Only a live (non-stale) ack outside a redirect cycle lands in the buffer.
  assign push       = (state_q == ST_REQ) && imem_ack_i && !branch_taken_i;
  assign valid_o    = !buf_empty && !branch_taken_i;
  assign pop        = valid_o && !freeze_i;
  assign cnt_next   = CW'(buf_count) + CW'(push) - CW'(pop);
  assign room       = (cnt_next < DEPTH_C);
  assign push_entry = '{pc: next_pc(fetch_pc_q), instr: imem_rdata_i};

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (branch_taken_i),
    .push_i  (push && (!buf_full || pop)),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!branch_taken_i && room) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (branch_taken_i)  state_d = imem_ack_i ? ST_IDLE : ST_DROP;
        else if (imem_ack_i) state_d = room ? ST_REQ : ST_IDLE;
      end
      ST_DROP: begin
        if (imem_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req_o    = (state_q != ST_IDLE);
    imem_addr_o   = addr_q;
    instruction_o = head.instr;
    pc_o          = head.pc;
  end

  // The bus address only moves when a new transfer starts, keeping it stable under req.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    if (branch_taken_i) fetch_pc_d = branch_addr_i;
    else if (push)      fetch_pc_d = next_pc(fetch_pc_q);
    if ((state_q == ST_IDLE) && (state_d == ST_REQ))
      addr_d = fetch_pc_q;
    else if ((state_q == ST_REQ) && (state_d == ST_REQ) && push)
      addr_d = next_pc(fetch_pc_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

endmodule
`default_nettype wire
